uart_echo_master: RTL and testbench
===================================

# uart_echo_master

Avalon-MM initiator that drives the UART FIFO peripheral's slave port. It polls the peripheral status register, pops each received byte from the RX FIFO, optionally transforms it, and pushes it into the TX FIFO, then triggers transmission. It sits between the peripheral's Avalon slave port and nothing else. It replaces a soft CPU for loopback, bring-up and link test.

## Interface
- P, 0, extra data bits (data width is 8+P); must match the peripheral.
- XOR_MASK, 0, value XORed onto each echoed word (width 8+P); 0 gives a pure echo.
- POLL_GAP, 4, idle cycles between status polls when there is nothing to do (≥1).

- clk  in  1  system clock; the block's only clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  level; when 0, no new transaction starts and the FSM finishes its current byte.
- address  out  2  Avalon address: 0 data_tx, 1 data_rx, 2 status, 3 control.
- chipselect  out  1  Avalon chipselect.
- read  out  1  Avalon read strobe.
- write  out  1  Avalon write strobe.
- writedata  out  32  Avalon write data.
- readdata  in  32  Avalon read data, valid the cycle after read is sampled.
- busy  out  1  high whenever the FSM is not in IDLE.
- echo_count  out  16  number of bytes fully echoed; wraps at 0xFFFF→0.
- last_byte  out  8+P  last value written to data_tx.

## Operation
- Peripheral map:
  - status[0] full_tx, [1] empty_tx, [2] full_rx, [3] empty_rx.
  - control[0] wr, [1] start, [2] rd; each bit is a one-shot.
- Every access is a single cycle with chipselect=1 and exactly one of read or write set. Otherwise all strobes are 0 and address and writedata are held at 0.
- A control write is always followed by at least one cycle with chipselect=0. The peripheral needs that cycle to self-clear control.
- FSM states and transitions:
  - IDLE: wait POLL_GAP cycles. Then, if enable=1, go to RS.
  - RS: issue read of address 2, go to RSW.
  - RSW: sample readdata.
    - If status[3]=1 (RX empty), go to IDLE.
    - Else capture tx_full=status[0] and go to RD.
  - RD: issue read of address 1, go to RDW.
  - RDW: latch byte = readdata[7+P:0] ^ XOR_MASK, go to POP.
  - POP: write control=32'h4 (rd), go to G1.
  - G1: one idle cycle, go to TS.
  - TS: issue read of address 2, go to TSW.
  - TSW: if status[0]=1 (TX full), go back to TS (spin). Else go to WD.
  - WD: write data_tx = zero-extended byte, go to PUSH.
  - PUSH: write control=32'h1 (wr), go to G2.
  - G2: one idle cycle, go to STRT.
  - STRT: write control=32'h2 (start), go to G3.
  - G3: one idle cycle, increment echo_count, update last_byte, go to IDLE.
- data_rx is read before rd is pulsed: the peripheral presents the FIFO head registered.
- Exactly one byte is echoed per pass; back-to-back bytes pass through IDLE.
- When enable falls mid-pass, the pass completes. No partial byte is ever left popped but not pushed.

## Timing
- Reset state: FSM in IDLE with the gap counter cleared. address=0, chipselect=0, read=0, write=0, writedata=0, busy=0, echo_count=0, last_byte=0.
- All outputs are registered, and strobes change only on clk rising edges.
- Minimum pass, with no TX-full spin: RS through G3 is 13 cycles.
- Idle poll period with RX empty: POLL_GAP+2 cycles.
- TX-full spin: 2 cycles per retry, unbounded. busy stays 1 throughout.
- Reset asserted mid-pass: everything aborts immediately to the reset state, and strobes drop asynchronously. A byte already popped is lost. This is accepted.
- echo_count increments exactly in G3. At 0xFFFF it wraps to 0.

## Structure
- Shared package (uart_avalon_pkg): register addresses (ADDR_TX=0, ADDR_RX=1, ADDR_STATUS=2, ADDR_CTRL=3), status bit indices, control bit masks, FSM state encoding.
- Sub-module avalon_mm_access: single-cycle read/write strobe generator with readdata capture. The FSM issues commands to it.
- Expected size: about 200 lines of RTL.

## Test plan
- Enable=1 with the peripheral RX empty → only status reads, one every POLL_GAP+2 cycles. No writes occur and echo_count stays 0.
- Inject 0x41 on tdi with XOR_MASK=0 → access order is status read, data_rx read, control=4, data_tx=0x41, control=1, control=2. Then 0x41 appears on tdo, echo_count=1, last_byte=0x41.
- XOR_MASK=0x20 with input 0x61 → transmitted byte is 0x41.
- Fill the TX FIFO (full_tx=1) before an RX byte arrives → FSM spins in TS/TSW with no data_tx write until full clears. Then it completes and the byte is not lost.
- Assert reset_n=0 during the PUSH cycle → all strobes are 0 immediately and echo_count=0. After release the FSM resumes polling from IDLE.
- Preload echo_count to 0xFFFF (force) and then echo one byte → echo_count=0.

Source files
------------

// File: rtl/uart_avalon_pkg.sv
// Shared register map, status/control encodings and FSM state codes for the
// UART FIFO peripheral Avalon slave and its echo initiator.
package uart_avalon_pkg;

  localparam logic [1:0] ADDR_TX     = 2'd0;
  localparam logic [1:0] ADDR_RX     = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  localparam int ST_FULL_TX  = 0;
  localparam int ST_EMPTY_TX = 1;
  localparam int ST_FULL_RX  = 2;
  localparam int ST_EMPTY_RX = 3;

  localparam logic [31:0] CTRL_WR    = 32'h0000_0001;
  localparam logic [31:0] CTRL_START = 32'h0000_0002;
  localparam logic [31:0] CTRL_RD    = 32'h0000_0004;

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_RS   = 4'd1;
  localparam logic [3:0] S_RSW  = 4'd2;
  localparam logic [3:0] S_RD   = 4'd3;
  localparam logic [3:0] S_RDW  = 4'd4;
  localparam logic [3:0] S_POP  = 4'd5;
  localparam logic [3:0] S_G1   = 4'd6;
  localparam logic [3:0] S_TS   = 4'd7;
  localparam logic [3:0] S_TSW  = 4'd8;
  localparam logic [3:0] S_WD   = 4'd9;
  localparam logic [3:0] S_PUSH = 4'd10;
  localparam logic [3:0] S_G2   = 4'd11;
  localparam logic [3:0] S_STRT = 4'd12;
  localparam logic [3:0] S_G3   = 4'd13;

endpackage

// File: rtl/avalon_mm_access.sv
// Single-cycle Avalon-MM strobe generator: registers one read or write command
// per cycle onto the bus and presents readdata in the cycle after a read.
module avalon_mm_access
  import uart_avalon_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_rd,
  input  logic        cmd_wr,
  input  logic [1:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [31:0] readdata,
  output logic [1:0]  address,
  output logic        chipselect,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [31:0] rdata
);

  logic [1:0]  address_r;
  logic        chipselect_r;
  logic        read_r;
  logic        write_r;
  logic [31:0] writedata_r;
  logic        rd_pending_r;

  // Bus strobes; address and writedata are held at zero between accesses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      address_r    <= 2'd0;
      chipselect_r <= 1'b0;
      read_r       <= 1'b0;
      write_r      <= 1'b0;
      writedata_r  <= 32'h0;
      rd_pending_r <= 1'b0;
    end else begin
      chipselect_r <= cmd_rd | cmd_wr;
      read_r       <= cmd_rd;
      write_r      <= cmd_wr & ~cmd_rd;
      address_r    <= (cmd_rd | cmd_wr) ? cmd_addr : 2'd0;
      writedata_r  <= (cmd_wr & ~cmd_rd) ? cmd_wdata : 32'h0;
      rd_pending_r <= read_r;
    end
  end

  assign address    = address_r;
  assign chipselect = chipselect_r;
  assign read       = read_r;
  assign write      = write_r;
  assign writedata  = writedata_r;
  assign rdata      = rd_pending_r ? readdata : 32'h0;

endmodule

// File: rtl/uart_echo_master.sv
// Avalon-MM initiator that polls the UART FIFO peripheral and echoes each
// received byte (optionally XOR-masked) back out through the TX FIFO.
module uart_echo_master
  import uart_avalon_pkg::*;
#(
  parameter int           P        = 0,
  parameter logic [7+P:0] XOR_MASK = {(8+P){1'b0}},
  parameter int           POLL_GAP = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         enable,
  output logic [1:0]   address,
  output logic         chipselect,
  output logic         read,
  output logic         write,
  output logic [31:0]  writedata,
  input  logic [31:0]  readdata,
  output logic         busy,
  output logic [15:0]  echo_count,
  output logic [7+P:0] last_byte
);

  localparam logic [15:0] GAP_LAST = 16'(POLL_GAP - 1);

  logic [3:0]   state_r;
  logic [3:0]   next_s;
  logic [15:0]  gap_cnt_r;
  logic         gap_done_s;
  logic [7+P:0] byte_r;
  logic [15:0]  echo_count_r;
  logic [7+P:0] last_byte_r;
  logic         busy_r;
  logic         cmd_rd_s;
  logic         cmd_wr_s;
  logic [1:0]   cmd_addr_s;
  logic [31:0]  cmd_wdata_s;
  logic [31:0]  rdata_s;

  assign gap_done_s = (gap_cnt_r >= GAP_LAST);

  // Next-state logic; enable is only consulted in IDLE so a started pass always completes.
  always_comb begin
    next_s = S_IDLE;
    case (state_r)
      S_IDLE: begin
        if (gap_done_s && enable) next_s = S_RS;
        else                      next_s = S_IDLE;
      end
      S_RS:  next_s = S_RSW;
      S_RSW: begin
        if (rdata_s[ST_EMPTY_RX]) next_s = S_IDLE;
        else                      next_s = S_RD;
      end
      S_RD:   next_s = S_RDW;
      S_RDW:  next_s = S_POP;
      S_POP:  next_s = S_G1;
      S_G1:   next_s = S_TS;
      S_TS:   next_s = S_TSW;
      S_TSW: begin
        if (rdata_s[ST_FULL_TX]) next_s = S_TS;
        else                     next_s = S_WD;
      end
      S_WD:   next_s = S_PUSH;
      S_PUSH: next_s = S_G2;
      S_G2:   next_s = S_STRT;
      S_STRT: next_s = S_G3;
      S_G3:   next_s = S_IDLE;
      default: next_s = S_IDLE;
    endcase
  end

  // Bus command for the state being entered, so strobes are valid for that whole state.
  always_comb begin
    cmd_rd_s    = 1'b0;
    cmd_wr_s    = 1'b0;
    cmd_addr_s  = ADDR_TX;
    cmd_wdata_s = 32'h0;
    case (next_s)
      S_RS, S_TS: begin
        cmd_rd_s   = 1'b1;
        cmd_addr_s = ADDR_STATUS;
      end
      S_RD: begin
        cmd_rd_s   = 1'b1;
        cmd_addr_s = ADDR_RX;
      end
      S_POP: begin
        cmd_wr_s    = 1'b1;
        cmd_addr_s  = ADDR_CTRL;
        cmd_wdata_s = CTRL_RD;
      end
      S_WD: begin
        cmd_wr_s    = 1'b1;
        cmd_addr_s  = ADDR_TX;
        cmd_wdata_s = 32'(byte_r);
      end
      S_PUSH: begin
        cmd_wr_s    = 1'b1;
        cmd_addr_s  = ADDR_CTRL;
        cmd_wdata_s = CTRL_WR;
      end
      S_STRT: begin
        cmd_wr_s    = 1'b1;
        cmd_addr_s  = ADDR_CTRL;
        cmd_wdata_s = CTRL_START;
      end
      default: begin
        cmd_rd_s = 1'b0;
      end
    endcase
  end

  // FSM state, poll gap counter, captured byte and echo statistics.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= S_IDLE;
      gap_cnt_r    <= 16'd0;
      byte_r       <= {(8+P){1'b0}};
      echo_count_r <= 16'd0;
      last_byte_r  <= {(8+P){1'b0}};
      busy_r       <= 1'b0;
    end else begin
      state_r <= next_s;
      busy_r  <= (next_s != S_IDLE);
      if (state_r != S_IDLE)
        gap_cnt_r <= 16'd0;
      else if (!gap_done_s)
        gap_cnt_r <= gap_cnt_r + 16'd1;
      if (state_r == S_RDW)
        byte_r <= rdata_s[7+P:0] ^ XOR_MASK;
      if (state_r == S_G3) begin
        echo_count_r <= echo_count_r + 16'd1;
        last_byte_r  <= byte_r;
      end
    end
  end

  avalon_mm_access u_access (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_rd     (cmd_rd_s),
    .cmd_wr     (cmd_wr_s),
    .cmd_addr   (cmd_addr_s),
    .cmd_wdata  (cmd_wdata_s),
    .readdata   (readdata),
    .address    (address),
    .chipselect (chipselect),
    .read       (read),
    .write      (write),
    .writedata  (writedata),
    .rdata      (rdata_s)
  );

  assign busy       = busy_r;
  assign echo_count = echo_count_r;
  assign last_byte  = last_byte_r;

endmodule

// File: tb/tb_uart_echo_master.sv
// Directed bench for uart_echo_master against a small behavioural model of the
// UART FIFO peripheral (XOR_MASK=0x20, POLL_GAP=4).
module tb_uart_echo_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [1:0]  address;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        busy;
  logic [15:0] echo_count;
  logic [7:0]  last_byte;

  uart_echo_master #(.P(0), .XOR_MASK(8'h20), .POLL_GAP(4)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .address(address),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .readdata(readdata), .busy(busy), .echo_count(echo_count), .last_byte(last_byte)
  );

  always #5 clk = ~clk;

  // Peripheral model state
  logic [7:0]  rx_q[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  tdo_q[$];
  logic [35:0] acc_q[$];
  int          st_cyc_q[$];
  logic [7:0]  tx_hold = 8'h00;
  logic        tx_full = 1'b0;
  logic [31:0] rd_q = 32'h0;
  int          cyc = 0;
  int          bad_wr = 0;
  int          gap_err = 0;
  logic        prev_ctrl = 1'b0;

  assign readdata = rd_q;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    prev_ctrl <= chipselect && write && (address == 2'd3);
    if (prev_ctrl && chipselect) gap_err <= gap_err + 1;
    if (chipselect) acc_q.push_back({read, write, address, writedata});
    if (chipselect && read) begin
      case (address)
        2'd1: rd_q <= (rx_q.size() != 0) ? {24'h0, rx_q[0]} : 32'h0;
        2'd2: begin
          rd_q <= {28'h0, rx_q.size() == 0, rx_q.size() >= 16, tx_q.size() == 0, tx_full};
          st_cyc_q.push_back(cyc);
        end
        default: rd_q <= 32'h0;
      endcase
    end else begin
      rd_q <= 32'h0;
    end
    if (chipselect && write) begin
      if (address == 2'd0) begin
        tx_hold <= writedata[7:0];
        if (tx_full) bad_wr <= bad_wr + 1;
      end
      if (address == 2'd3) begin
        if (writedata[2] && rx_q.size() != 0) void'(rx_q.pop_front());
        if (writedata[0]) tx_q.push_back(tx_hold);
        if (writedata[1]) while (tx_q.size() != 0) tdo_q.push_back(tx_q.pop_front());
      end
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_count(input logic [15:0] target, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      if (echo_count == target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic logic [15:0] pop_tdo();
    if (tdo_q.size() == 0) return 16'hFFFF;
    return {8'h00, tdo_q.pop_front()};
  endfunction

  typedef struct {
    logic [7:0] rx;
    int         full_cyc;
    logic [7:0] exp_tx;
  } vec_t;

  vec_t        vecs[5];
  logic [35:0] exp_seq[5];

  initial begin
    bit  ok;
    int  base;
    int  n;
    bit  ok_ord;
    int  nst;

    vecs[0] = '{8'h61, 0,  8'h41};
    vecs[1] = '{8'h41, 0,  8'h61};
    vecs[2] = '{8'h00, 40, 8'h20};
    vecs[3] = '{8'hFF, 0,  8'hDF};
    vecs[4] = '{8'h20, 0,  8'h00};

    reset_n = 1'b0;
    enable  = 1'b0;
    #3;
    check("reset_bus", {chipselect, read, write, address, writedata[26:0]}, 32'h0);
    check("reset_wd", writedata, 32'h0);
    check("reset_stat", {busy, echo_count, last_byte}, 32'h0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    enable = 1'b1;

    // Idle polling with RX empty: status reads only, period POLL_GAP+2.
    base = st_cyc_q.size();
    n = acc_q.size();
    repeat (40) @(posedge clk);
    #1;
    nst = st_cyc_q.size() - base;
    check("idle_nreads", (nst >= 5) ? 32'd1 : 32'd0, 32'd1);
    for (int k = 1; k < 5; k++)
      if (base + k < st_cyc_q.size())
        check("idle_period", st_cyc_q[base+k] - st_cyc_q[base+k-1], 32'd6);
    ok = 1'b1;
    for (int k = n; k < acc_q.size(); k++)
      if (acc_q[k][34] || acc_q[k][33:32] != 2'd2) ok = 1'b0;
    check("idle_only_status", ok, 1);
    check("idle_count", echo_count, 32'd0);

    // Table-driven echo passes.
    for (int i = 0; i < 5; i++) begin
      base = acc_q.size();
      n = bad_wr;
      exp_seq[0] = {1'b1, 1'b0, 2'd1, 32'h0};
      exp_seq[1] = {1'b0, 1'b1, 2'd3, 32'h4};
      exp_seq[2] = {1'b0, 1'b1, 2'd0, 24'h0, vecs[i].exp_tx};
      exp_seq[3] = {1'b0, 1'b1, 2'd3, 32'h1};
      exp_seq[4] = {1'b0, 1'b1, 2'd3, 32'h2};
      tx_full = (vecs[i].full_cyc > 0);
      rx_q.push_back(vecs[i].rx);
      if (vecs[i].full_cyc > 0) begin
        repeat (vecs[i].full_cyc) @(posedge clk);
        #1;
        check("spin_busy", busy, 1);
        check("spin_count", echo_count, i);
        tx_full = 1'b0;
      end
      wait_count(16'(i + 1), ok);
      check("pass_done", ok, 1);
      check("tdo", pop_tdo(), vecs[i].exp_tx);
      check("last_byte", last_byte, vecs[i].exp_tx);
      check("no_wr_while_full", bad_wr - n, 32'd0);
      nst = 0;
      ok_ord = 1'b1;
      for (int k = base; k < acc_q.size(); k++)
        if (!(acc_q[k][35] && acc_q[k][33:32] == 2'd2)) begin
          if (nst >= 5 || acc_q[k] != exp_seq[nst]) ok_ord = 1'b0;
          nst++;
        end
      check("order_ok", ok_ord, 1);
      check("order_len", nst, 5);
    end

    // Enable falls mid-pass: the pass completes, then polling stops.
    rx_q.push_back(8'h55);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (write && address == 2'd3 && writedata == 32'h4) begin
        ok = 1'b1;
        break;
      end
    end
    check("en_reach_pop", ok, 1);
    enable = 1'b0;
    wait_count(16'd6, ok);
    check("en_pass_done", ok, 1);
    check("en_tdo", pop_tdo(), 8'h75);
    base = acc_q.size();
    repeat (30) @(posedge clk);
    #1;
    check("en_quiet", acc_q.size() - base, 32'd0);
    check("en_busy", busy, 0);

    // Reset during PUSH: strobes drop at once, counters clear.
    enable = 1'b1;
    rx_q.push_back(8'h12);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (write && address == 2'd3 && writedata == 32'h1) begin
        ok = 1'b1;
        break;
      end
    end
    check("rst_reach_push", ok, 1);
    reset_n = 1'b0;
    #1;
    check("rst_strobes", {chipselect, read, write, address}, 32'h0);
    check("rst_wd", writedata, 32'h0);
    check("rst_count", echo_count, 32'd0);
    check("rst_busy", {busy, last_byte}, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (chipselect && read && address == 2'd2) begin
        ok = 1'b1;
        break;
      end
    end
    check("rst_resume_poll", ok, 1);

    // echo_count wraps from 0xFFFF to 0.
    force dut.echo_count_r = 16'hFFFF;
    #2;
    release dut.echo_count_r;
    rx_q.push_back(8'h01);
    wait_count(16'h0000, ok);
    check("wrap_count", {ok, echo_count}, {16'h0001, 16'h0000});
    check("wrap_last", last_byte, 8'h21);
    repeat (5) @(posedge clk);
    #1;
    check("ctrl_gap", gap_err, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
